ipv_reducer_mc: RTL
===================

IPV_REDUCER_MC -- requirements
Module: ipv_reducer_mc

Interface
REQ-001 Parameter K, default 4: samples per group; legal range 2..16.
REQ-002 Parameter CH, default 2: number of independent IPV channels; legal range 1..8.
REQ-003 Parameter LAT, default 3: output pipeline depth in cycles; legal range 1..8.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 valid_i  input  1  the ipv_i sample is valid this cycle.
REQ-007 ipv_i  input  CH  one IPV sample bit per channel; channel c on bit c.
REQ-008 flush_i  input  1  close the current partial group.
REQ-009 mode_i  input  1  output encoding: 0 = thermometer, 1 = binary count.
REQ-010 vov_o  output  CH*K  per-channel reduced vector; channel c on bits [c*K +: K].
REQ-011 len_o  output  CW  number of samples in the emitted group, where CW = clog2(K+1).
REQ-012 vov_valid_o  output  1  single-cycle strobe; vov_o and len_o are meaningful.

Function
REQ-013 A group counter cnt (0..K-1) SHALL advance only on valid_i=1 and wrap to 0 after K-1.
REQ-014 Per-channel accumulator acc[K-1:0] on a valid sample with cnt=0: SHALL load {ipv_i[c], 0...0}.
REQ-015 Per-channel accumulator acc on a valid sample with cnt>0: SHALL load {1, acc[K-1:1]} if ipv_i[c]=1, else hold.
REQ-016 Net effect: acc SHALL be an MSB-justified thermometer code of the ones count in the group.
REQ-017 A group SHALL close on the edge sampling valid_i=1 with cnt=K-1; the closing sample SHALL be included in the result.
REQ-018 A group SHALL close on flush_i=1 when cnt>0 or valid_i=1.
REQ-019 If valid_i and flush_i are asserted in the same cycle, the sample SHALL be included and the group closed.
REQ-020 A flush with cnt=0 and valid_i=0 SHALL be ignored: no strobe, no state change.
REQ-021 On close, cnt SHALL return to 0.
REQ-022 On close, the result SHALL be written to pipeline stage 0 as follows:
- per-channel vector per the mode_i value sampled at the closing edge;
- len = number of samples in the group (K for a natural close, 1..K for a flush);
- valid = 1.
REQ-023 Mode 0 SHALL output the thermometer code acc as-is.
REQ-024 Mode 1 SHALL output the ones count, zero-extended into K bits.
REQ-025 Cycles with no close SHALL write zeros (vector, len, valid) into stage 0.
REQ-026 Pipeline stages 1..LAT-1 SHALL shift every cycle unconditionally; outputs SHALL be driven from stage LAT-1.
REQ-027 Latency: a group closed at edge n SHALL appear on the outputs after edge n+LAT-1 and SHALL hold for exactly one cycle.
REQ-028 vov_o and len_o SHALL be zero whenever vov_valid_o=0.
REQ-029 Back-to-back groups (with K consecutive valid samples) SHALL produce strobes exactly K cycles apart, with no lost samples.
REQ-030 There SHALL be no backpressure; outputs are not held for a consumer.

Reset
REQ-031 rst=1 SHALL asynchronously clear cnt, all acc registers and all pipeline stages.
REQ-032 While rst=1, vov_o=0, len_o=0 and vov_valid_o=0.
REQ-033 Reset mid-group or mid-pipeline SHALL discard all in-flight data; the first sample after release SHALL start a new group at cnt=0.

Structure
REQ-034 A shared package ipv_pkg SHALL hold:
- the default K, CH and LAT values;
- the mode encoding constants (MODE_THERM=0, MODE_COUNT=1);
- a width function for CW.
REQ-035 Per-channel accumulation and the ones count SHALL live in a sub-module ipv_lane, instantiated CH times; cnt, close logic and the pipeline SHALL live in the top level.

Verification (K=4, CH=2, LAT=3)
REQ-036 Reset: assert rst mid-stream; all outputs 0 immediately (asynchronously); after release, the next 4 samples form one complete group.
REQ-037 Thermometer mode: ch0 = 1,0,1,1 and ch1 = 0,0,0,1 on consecutive valid edges 1..4 -> after edge 6, vov_valid_o=1, ch0=4'b1110, ch1=4'b1000, len_o=4; all outputs 0 after edge 7.
REQ-038 Count mode with gaps: the same samples with valid_i low between them and mode_i=1 -> ch0=4'b0011, ch1=4'b0001, len_o=4; the result is unchanged by the gaps.
REQ-039 Flush: samples ch0 = 1,1, then flush_i alone -> ch0=4'b1100, len_o=2; a further flush_i with cnt=0 -> no strobe.
REQ-040 Simultaneous valid and flush on the 3rd sample (ch0 = 1,0,1) -> ch0=4'b1100, len_o=3, cnt=0 afterwards.
REQ-041 Continuous valid for 12 cycles -> exactly three strobes, 4 cycles apart, each with correct per-group data.

Source files
------------

// File: rtl/ipv_pkg.sv
// Shared constants and helpers for the IPV reducer: default geometry,
// output-mode encoding and the group-length width function.
package ipv_pkg;

    localparam int unsigned K_DEF   = 4;
    localparam int unsigned CH_DEF  = 2;
    localparam int unsigned LAT_DEF = 3;

    localparam logic MODE_THERM = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

    // Width needed to hold a group length in the range 0..k
    function automatic int unsigned cw_of(input int unsigned k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/ipv_lane.sv
// One IPV channel: MSB-justified thermometer accumulator plus the ones count
// of the value it will hold after the current edge (includes this sample).
module ipv_lane #(
    parameter int unsigned K  = 4,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_i,
    input  logic          first_i,
    input  logic          ipv_i,
    output logic [K-1:0]  acc_next_o,
    output logic [CW-1:0] ones_o
);

    logic [K-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (sample_i) begin
            if (first_i) begin
                acc_d = {ipv_i, {(K-1){1'b0}}};
            end else if (ipv_i) begin
                acc_d = {1'b1, acc_q[K-1:1]};
            end
        end
    end

    always_comb begin
        ones_o = '0;
        for (int unsigned i = 0; i < K; i++) begin
            ones_o = ones_o + CW'(acc_d[i]);
        end
    end

    assign acc_next_o = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ipv_reducer_mc.sv
// Multi-channel IPV group reducer: collects K samples (or a flushed partial
// group) per channel and emits a thermometer or count vector after LAT cycles.
module ipv_reducer_mc
    import ipv_pkg::*;
#(
    parameter int unsigned K   = K_DEF,
    parameter int unsigned CH  = CH_DEF,
    parameter int unsigned LAT = LAT_DEF,
    localparam int unsigned CW = cw_of(K)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [CH-1:0]   ipv_i,
    input  logic            flush_i,
    input  logic            mode_i,
    output logic [CH*K-1:0] vov_o,
    output logic [CW-1:0]   len_o,
    output logic            vov_valid_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          close;
    logic [CW-1:0] grp_len;

    logic [K-1:0]  acc_next [CH];
    logic [CW-1:0] ones     [CH];
    logic [CH*K-1:0] res_vec;

    logic [CH*K-1:0] vec_q [LAT];
    logic [CH*K-1:0] vec_d [LAT];
    logic [CW-1:0]   len_q [LAT];
    logic [CW-1:0]   len_d [LAT];
    logic [LAT-1:0]  vld_q, vld_d;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        ipv_lane #(
            .K  (K),
            .CW (CW)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .sample_i   (valid_i),
            .first_i    (cnt_q == '0),
            .ipv_i      (ipv_i[c]),
            .acc_next_o (acc_next[c]),
            .ones_o     (ones[c])
        );
    end

    // A flush with nothing collected and no sample this cycle is a no-op
    always_comb begin
        close   = (valid_i && (cnt_q == CW'(K - 1)))
                  || (flush_i && ((cnt_q != '0) || valid_i));
        grp_len = cnt_q + CW'(valid_i);
        cnt_d   = cnt_q;
        if (close) begin
            cnt_d = '0;
        end else if (valid_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        res_vec = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (mode_i == MODE_COUNT) begin
                res_vec[c*K +: K] = K'(ones[c]);
            end else begin
                res_vec[c*K +: K] = acc_next[c];
            end
        end
    end

    always_comb begin
        vec_d[0] = close ? res_vec : '0;
        len_d[0] = close ? grp_len : '0;
        vld_d    = '0;
        vld_d[0] = close;
        for (int unsigned i = 1; i < LAT; i++) begin
            vec_d[i] = vec_q[i-1];
            len_d[i] = len_q[i-1];
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            vld_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                vec_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            for (int unsigned i = 0; i < LAT; i++) begin
                vec_q[i] <= vec_d[i];
                len_q[i] <= len_d[i];
            end
        end
    end

    assign vov_o       = vec_q[LAT-1];
    assign len_o       = len_q[LAT-1];
    assign vov_valid_o = vld_q[LAT-1];

endmodule
